register_file_multiport: RTL and testbench

//   Parametrised general-purpose register file for the next datapath generation:
//   2 write ports, 3 combinational read ports, per-register pending scoreboard.

---
 rtl/register_file_multiport.sv | 114 +++++++++++
 tb/tb_register_file_multiport.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_multiport.sv
// Multiport register file: two write ports, three combinational read ports, per-register pending scoreboard.
// Optional write-first read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enabled_a,
  input  logic [ADDR_WIDTH-1:0] register_destiny_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic                  write_enabled_b,
  input  logic [ADDR_WIDTH-1:0] register_destiny_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic                  reserve_enabled,
  input  logic [ADDR_WIDTH-1:0] register_reserve,
  input  logic [ADDR_WIDTH-1:0] register_source1,
  input  logic [ADDR_WIDTH-1:0] register_source2,
  input  logic [ADDR_WIDTH-1:0] register_source3,
  output logic [DATA_WIDTH-1:0] register_base_out1,
  output logic [DATA_WIDTH-1:0] register_base_out2,
  output logic [DATA_WIDTH-1:0] register_base_out3,
  output logic                  pending1,
  output logic                  pending2,
  output logic                  pending3,
  output logic                  write_collision
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic                  ZERO_EN   = (ZERO_REG != 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]      pending_r;
  logic                  collision_r;

  logic                  we_a_s;
  logic                  we_b_s;
  logic                  res_s;
  logic                  collision_s;
  logic [ADDR_WIDTH-1:0] src_s   [3];
  logic [DATA_WIDTH-1:0] rdata_s [3];
  logic                  rpend_s [3];

  // Qualified write/reserve strobes; the hardwired-zero register and an asserted reset drop them.
  always_comb begin
    we_a_s      = write_enabled_a & ~reset & ~(ZERO_EN & (register_destiny_a == ADDR_ZERO));
    we_b_s      = write_enabled_b & ~reset & ~(ZERO_EN & (register_destiny_b == ADDR_ZERO));
    res_s       = reserve_enabled & ~reset & ~(ZERO_EN & (register_reserve == ADDR_ZERO));
    collision_s = we_a_s & we_b_s & (register_destiny_a == register_destiny_b);
  end

  // Register array, scoreboard and collision flag; B beats A, a reserve beats a same-cycle write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
      pending_r   <= {DEPTH{1'b0}};
      collision_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_b_s && (register_destiny_b == ADDR_WIDTH'(i))) begin
          regs_r[i] <= write_data_b;
        end else if (we_a_s && (register_destiny_a == ADDR_WIDTH'(i))) begin
          regs_r[i] <= write_data_a;
        end
        if (res_s && (register_reserve == ADDR_WIDTH'(i))) begin
          pending_r[i] <= 1'b1;
        end else if ((we_a_s && (register_destiny_a == ADDR_WIDTH'(i))) ||
                     (we_b_s && (register_destiny_b == ADDR_WIDTH'(i)))) begin
          pending_r[i] <= 1'b0;
        end
      end
      collision_r <= collision_s;
    end
  end

  assign src_s[0] = register_source1;
  assign src_s[1] = register_source2;
  assign src_s[2] = register_source3;

  // Read ports: state lookup, optional same-cycle forwarding, then zero-register masking.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata_s[p] = regs_r[src_s[p]];
      rpend_s[p] = pending_r[src_s[p]];
`ifdef REGFILE_BYPASS_EN
      if (we_b_s && (register_destiny_b == src_s[p])) begin
        rdata_s[p] = write_data_b;
        rpend_s[p] = res_s && (register_reserve == src_s[p]);
      end else if (we_a_s && (register_destiny_a == src_s[p])) begin
        rdata_s[p] = write_data_a;
        rpend_s[p] = res_s && (register_reserve == src_s[p]);
      end else begin
        rdata_s[p] = regs_r[src_s[p]];
        rpend_s[p] = pending_r[src_s[p]];
      end
`endif
      rdata_s[p] = (ZERO_EN && (src_s[p] == ADDR_ZERO)) ? {DATA_WIDTH{1'b0}} : rdata_s[p];
      rpend_s[p] = (ZERO_EN && (src_s[p] == ADDR_ZERO)) ? 1'b0 : rpend_s[p];
    end
  end

  assign register_base_out1 = rdata_s[0];
  assign register_base_out2 = rdata_s[1];
  assign register_base_out3 = rdata_s[2];
  assign pending1           = rpend_s[0];
  assign pending2           = rpend_s[1];
  assign pending3           = rpend_s[2];
  assign write_collision    = collision_r;

endmodule

// File: tb/tb_register_file_multiport.sv
// Scoreboard bench for register_file_multiport (default parameters, ZERO_REG=1).
// Expected read/pending/collision values are queued when stimulus is applied and popped when sampled.
module tb_register_file_multiport;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enabled_a, write_enabled_b, reserve_enabled;
  logic [4:0]  register_destiny_a, register_destiny_b, register_reserve;
  logic [31:0] write_data_a, write_data_b;
  logic [4:0]  register_source1, register_source2, register_source3;
  logic [31:0] register_base_out1, register_base_out2, register_base_out3;
  logic        pending1, pending2, pending3, write_collision;

  register_file_multiport dut (
    .clock              (clock),
    .reset              (reset),
    .write_enabled_a    (write_enabled_a),
    .register_destiny_a (register_destiny_a),
    .write_data_a       (write_data_a),
    .write_enabled_b    (write_enabled_b),
    .register_destiny_b (register_destiny_b),
    .write_data_b       (write_data_b),
    .reserve_enabled    (reserve_enabled),
    .register_reserve   (register_reserve),
    .register_source1   (register_source1),
    .register_source2   (register_source2),
    .register_source3   (register_source3),
    .register_base_out1 (register_base_out1),
    .register_base_out2 (register_base_out2),
    .register_base_out3 (register_base_out3),
    .pending1           (pending1),
    .pending2           (pending2),
    .pending3           (pending3),
    .write_collision    (write_collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  int          checks = 0;
  int          errors = 0;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pop_check(input logic [31:0] observed);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=queued_entry", observed);
    end else begin
      e = exp_q.pop_front();
      check_value(e.tag, observed, e.value);
    end
  endtask

  function automatic logic wa_q();
    return write_enabled_a && (register_destiny_a != 5'd0);
  endfunction

  function automatic logic wb_q();
    return write_enabled_b && (register_destiny_b != 5'd0);
  endfunction

  function automatic logic res_q();
    return reserve_enabled && (register_reserve != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_q() && (register_destiny_b == addr)) return write_data_b;
    if (wa_q() && (register_destiny_a == addr)) return write_data_a;
`endif
    return m_regs[addr];
  endfunction

  function automatic logic exp_pend(input logic [4:0] addr);
    if (addr == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wb_q() && (register_destiny_b == addr)) || (wa_q() && (register_destiny_a == addr)))
      return res_q() && (register_reserve == addr);
`endif
    return m_pend[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 32'd0;
  endtask

  // One clock of stimulus: queue expectations, check reads before the edge, collision after it.
  task automatic cycle(input logic wea, input logic [4:0] da, input logic [31:0] wda,
                       input logic web, input logic [4:0] db, input logic [31:0] wdb,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    write_enabled_a = wea; register_destiny_a = da; write_data_a = wda;
    write_enabled_b = web; register_destiny_b = db; write_data_b = wdb;
    reserve_enabled = re;  register_reserve = ra;
    register_source1 = s1; register_source2 = s2; register_source3 = s3;
    exp_q.push_back('{tag: "out1", value: exp_read(s1)});
    exp_q.push_back('{tag: "out2", value: exp_read(s2)});
    exp_q.push_back('{tag: "out3", value: exp_read(s3)});
    exp_q.push_back('{tag: "pending1", value: {31'd0, exp_pend(s1)}});
    exp_q.push_back('{tag: "pending2", value: {31'd0, exp_pend(s2)}});
    exp_q.push_back('{tag: "pending3", value: {31'd0, exp_pend(s3)}});
    exp_q.push_back('{tag: "collision", value: {31'd0, wa_q() && wb_q() && (da == db)}});
    #1;
    pop_check(register_base_out1);
    pop_check(register_base_out2);
    pop_check(register_base_out3);
    pop_check({31'd0, pending1});
    pop_check({31'd0, pending2});
    pop_check({31'd0, pending3});
    if (wa_q()) begin m_regs[da] = wda; m_pend[da] = 1'b0; end
    if (wb_q()) begin m_regs[db] = wdb; m_pend[db] = 1'b0; end
    if (res_q()) m_pend[ra] = 1'b1;
    @(posedge clock);
    #1;
    pop_check({31'd0, write_collision});
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, s1, s2, s3);
  endtask

  initial begin
    reset = 1'b1;
    write_enabled_a = 1'b0; register_destiny_a = 5'd0; write_data_a = 32'd0;
    write_enabled_b = 1'b0; register_destiny_b = 5'd0; write_data_b = 32'd0;
    reserve_enabled = 1'b0; register_reserve = 5'd0;
    register_source1 = 5'd1; register_source2 = 5'd2; register_source3 = 5'd3;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_value("reset_out1", register_base_out1, 32'd0);
    check_value("reset_pending1", {31'd0, pending1}, 32'd0);
    check_value("reset_collision", {31'd0, write_collision}, 32'd0);
    reset = 1'b0;

    // Write A then read on the next cycle; register 0 reads zero.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    idle(5'd5, 5'd0, 5'd5);
    check_value("t2_out1", register_base_out1, 32'hDEADBEEF);
    check_value("t2_out2", register_base_out2, 32'd0);

    // Same-address collision: B wins, flag for exactly one cycle.
    cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 5'd0);
    check_value("t3_collision_set", {31'd0, write_collision}, 32'd1);
    idle(5'd7, 5'd0, 5'd0);
    check_value("t3_out1", register_base_out1, 32'h22);
    check_value("t3_collision_clr", {31'd0, write_collision}, 32'd0);

    // Scoreboard: reserve, clear by write, reserve beats same-cycle write.
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7, 5'd0);
    idle(5'd3, 5'd0, 5'd0);
    check_value("t4_pending_set", {31'd0, pending1}, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 5'd3, 5'd0, 5'd0);
    idle(5'd3, 5'd0, 5'd0);
    check_value("t4_pending_clr", {31'd0, pending1}, 32'd0);
    check_value("t4_out1", register_base_out1, 32'h5);
    cycle(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0, 5'd0);
    idle(5'd3, 5'd0, 5'd0);
    check_value("t4_reserve_wins", {31'd0, pending1}, 32'd1);
    check_value("t4_out1_new", register_base_out1, 32'h77);

    // Register 0 ignores writes, reserves and collisions.
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    check_value("t5_no_collision", {31'd0, write_collision}, 32'd0);
    idle(5'd0, 5'd0, 5'd0);
    check_value("t5_out1", register_base_out1, 32'd0);
    check_value("t5_pending1", {31'd0, pending1}, 32'd0);

    // Same-cycle read of a register being written (forwarded only with bypass).
    cycle(1'b1, 5'd9, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd9);
    idle(5'd0, 5'd0, 5'd9);
    check_value("t6_out3_after", register_base_out3, 32'hA5);

    // Reset mid-run with a write in flight: everything clears, the write is lost.
    write_enabled_a = 1'b1; register_destiny_a = 5'd5; write_data_a = 32'h1234;
    register_source1 = 5'd5; register_source2 = 5'd7; register_source3 = 5'd3;
    reset = 1'b1;
    #1;
    check_value("t1_out1", register_base_out1, 32'd0);
    check_value("t1_out2", register_base_out2, 32'd0);
    check_value("t1_pending3", {31'd0, pending3}, 32'd0);
    check_value("t1_collision", {31'd0, write_collision}, 32'd0);
    @(posedge clock);
    #1;
    check_value("t1_write_lost", register_base_out1, 32'd0);
    reset = 1'b0;
    model_clear();
    idle(5'd5, 5'd7, 5'd3);

    // Random traffic over a small address window to exercise collisions and reserves.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
